mycpu_pipe_ctrl: RTL and testbench
==================================

Name: mycpu_pipe_ctrl

Overview:
Pipeline sequencer and interlock controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Owns per-stage valid bits and a shadow copy of each in-flight instruction's destination, write-enable and load flag.
- Drives the stage register enables and the ID-stage operand stall/forward selects feeding the decoder's A/B and branch compare.
- Holds the pipe while the data memory handshake is outstanding.

Parameters:
REG_ADDR_W, 5, register-file address width
STALL_CNT_W, 32, width of stall performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
if_valid  input  1  IF holds a fetched instruction
id_rs  input  REG_ADDR_W  ID source 1 address
id_rt  input  REG_ADDR_W  ID source 2 address
id_rs_used  input  1  ID instruction reads rs
id_rt_used  input  1  ID instruction reads rt
id_dest  input  REG_ADDR_W  ID target register (decoder targetReg)
id_wen  input  1  ID instruction writes register file
id_is_load  input  1  ID instruction is LW
id_is_mem  input  1  ID instruction is LW or SW
id_br_taken  input  1  ID branch/jump resolved taken (C1 != 0, taken)
mem_done  input  1  data memory completed MEM-stage access this cycle
pc_en  output  1  PC update enable
if_id_en  output  1  IF/ID register load
id_ex_en  output  1  ID/EX register load
ex_mem_en  output  1  EX/MEM register load
mem_wb_en  output  1  MEM/WB register load
id_valid, ex_valid, mem_valid, wb_valid  output  1 each  stage valid bits
stall_id  output  1  ID held by hazard
br_redirect  output  1  PC takes jmpAddr this cycle
fwd_sel_a  output  2  rs source: 00 regfile, 01 MEM-stage result, 10 WB data
fwd_sel_b  output  2  rt source, same encoding
rf_wen  output  1  register-file write, = wb_valid & wb_wen
stall_cnt  output  STALL_CNT_W  cycles with stall_id or mem hold

Behaviour:
- Reset (rst=0, async): all valid bits 0, shadow fields 0, stall_cnt 0.
  - Combinational outputs then evaluate to pc_en=1, if_id_en=1, stall_id=0, fwd_sel=00, br_redirect=0, rf_wen=0.
- Shadow state per stage: valid, dest, wen, is_load, is_mem. It moves with the corresponding stage enable.
- Allow-in chain, with all terms combinational:
  - mem_hold = mem_valid & mem_is_mem & ~mem_done.
  - WB always retires.
  - mem_allow = ~mem_hold.
  - ex_allow = ~ex_valid | mem_allow.
  - id_go = id_valid & ~stall_id & ex_allow.
  - id_allow = ~id_valid | id_go.
- Enables:
  - pc_en = if_id_en = id_allow.
  - id_ex_en = ex_allow.
  - ex_mem_en = mem_allow.
  - mem_wb_en = 1.
- Bubbles: a stage that loads while its predecessor did not advance receives valid=0.
  - MEM hold: wb_valid goes 0 next cycle.
  - ID stall: ex_valid goes 0 next cycle if EX advanced.
- Hazard match for a source: used & addr!=0 & stage_valid & stage_wen & stage_dest==addr. Register 0 never matches.
- Hazard priority is youngest first: EX > MEM > WB.
- Without FORWARD_EN:
  - stall_id = any match in EX, MEM or WB. The register file is not write-through.
  - fwd_sel = 00 always.
- br_redirect = id_go & id_br_taken. No IF flush: the IF instruction is the delay slot and proceeds.
- stall_cnt increments (wrapping) in any cycle with id_valid & ~id_go. It holds otherwise.
- Simultaneous mem_hold and hazard: both hold ID; stall_cnt counts the cycle once.

Optional Feature:
FORWARD_EN
- Defined:
  - EX match → stall (result not ready before end of EX).
  - MEM match:
    - non-load → fwd 01, no stall.
    - load → stall until the load reaches WB.
  - WB match → fwd 10, no stall.
- Undefined: full interlock as above, fwd_sel tied 00.

Decomposition:
- Shared package mycpu_pipe_pkg:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - Stage shadow struct/typedef {valid, dest, wen, is_load, is_mem}.
- Sub-module mycpu_hazard_cmp: per-source comparison against EX/MEM/WB shadows, returning stall and fwd_sel. Instantiated twice (rs, rt).

Test Plan:
- addu $3 then addu $4,$3,$1 back-to-back.
  - No FORWARD_EN: stall_id high 3 cycles, fwd_sel_a=00.
  - FORWARD_EN: stall 1 cycle, then fwd_sel_a=01.
- lw $5 (mem_done same cycle) then beq $5,$0, FORWARD_EN: stall 2 cycles, then fwd_sel_a=10, br_redirect=1 for 1 cycle.
- addu $0,... then addu $6,$0,$0: stall_id never asserts, fwd_sel=00.
- sw in MEM with mem_done low 4 cycles:
  - pc_en, if_id_en, id_ex_en, ex_mem_en low 4 cycles; wb_valid 0 for 4 cycles.
  - stall_cnt +4.
- Taken branch in ID while hazard-stalled 2 cycles: br_redirect low during stall, high exactly in the id_go cycle.
- rst pulsed low mid-stall: all valid bits, stall_cnt and stall_id 0 immediately (before next clk edge); pc_en=1.

Source files
------------

// File: rtl/mycpu_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline controller.
package mycpu_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned SHADOW_DEST_W = 5;

  typedef struct packed {
    logic                     valid;
    logic [SHADOW_DEST_W-1:0] dest;
    logic                     wen;
    logic                     is_load;
    logic                     is_mem;
  } stage_shadow_t;

  // A source matches a stage only if that stage will write a non-zero register it reads.
  function automatic logic src_hit(stage_shadow_t s, logic [SHADOW_DEST_W-1:0] addr,
                                   logic used);
    return used && (addr != '0) && s.valid && s.wen && (s.dest == addr);
  endfunction

endpackage

// File: rtl/mycpu_pipe_ctrl_if.sv
// Core <-> pipeline controller bundle: ID decode info and MEM handshake in, enables/selects out.
interface mycpu_pipe_ctrl_if #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned STALL_CNT_W = 32
);

  logic                   if_valid;
  logic [REG_ADDR_W-1:0]  id_rs;
  logic [REG_ADDR_W-1:0]  id_rt;
  logic                   id_rs_used;
  logic                   id_rt_used;
  logic [REG_ADDR_W-1:0]  id_dest;
  logic                   id_wen;
  logic                   id_is_load;
  logic                   id_is_mem;
  logic                   id_br_taken;
  logic                   mem_done;

  logic                   pc_en;
  logic                   if_id_en;
  logic                   id_ex_en;
  logic                   ex_mem_en;
  logic                   mem_wb_en;
  logic                   id_valid;
  logic                   ex_valid;
  logic                   mem_valid;
  logic                   wb_valid;
  logic                   stall_id;
  logic                   br_redirect;
  logic [1:0]             fwd_sel_a;
  logic [1:0]             fwd_sel_b;
  logic                   rf_wen;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output if_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dest, id_wen, id_is_load,
           id_is_mem, id_br_taken, mem_done,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_valid, ex_valid, mem_valid,
           wb_valid, stall_id, br_redirect, fwd_sel_a, fwd_sel_b, rf_wen, stall_cnt
  );

  modport slave (
    input  if_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dest, id_wen, id_is_load,
           id_is_mem, id_br_taken, mem_done,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_valid, ex_valid, mem_valid,
           wb_valid, stall_id, br_redirect, fwd_sel_a, fwd_sel_b, rf_wen, stall_cnt
  );

endinterface

// File: rtl/mycpu_hazard_cmp.sv
// One ID source operand checked against the EX/MEM/WB shadows; yields stall and forward select.
// FORWARD_EN enables MEM/WB bypassing; otherwise any match interlocks.
module mycpu_hazard_cmp
  import mycpu_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  used,
    input  stage_shadow_t         ex_s,
    input  stage_shadow_t         mem_s,
    input  stage_shadow_t         wb_s,
    output logic                  stall,
    output logic [1:0]            fwd_sel
);

  logic hit_ex, hit_mem, hit_wb;
  logic unused_shadow;

  assign hit_ex  = src_hit(ex_s, SHADOW_DEST_W'(addr), used);
  assign hit_mem = src_hit(mem_s, SHADOW_DEST_W'(addr), used);
  assign hit_wb  = src_hit(wb_s, SHADOW_DEST_W'(addr), used);

  assign unused_shadow = ^{ex_s.is_load, ex_s.is_mem, mem_s.is_load, mem_s.is_mem,
                           wb_s.is_load, wb_s.is_mem};

  always_comb begin
    stall   = 1'b0;
    fwd_sel = FWD_RF;
`ifdef FORWARD_EN
    // Youngest producer wins; an EX result or an unfinished load cannot be bypassed yet.
    if (hit_ex) begin
      stall = 1'b1;
    end else if (hit_mem) begin
      if (mem_s.is_load) stall = 1'b1;
      else               fwd_sel = FWD_MEM;
    end else if (hit_wb) begin
      fwd_sel = FWD_WB;
    end
`else
    stall = hit_ex | hit_mem | hit_wb;
`endif
  end

endmodule

// File: rtl/mycpu_pipe_ctrl.sv
// Pipeline sequencer/interlock for the IF/ID/EX/MEM/WB core: valid bits, shadows, enables,
// hazard stall and forwarding selects. Optional bypassing is enabled with FORWARD_EN.
module mycpu_pipe_ctrl
  import mycpu_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned STALL_CNT_W = 32
) (
    input logic              clk,
    input logic              rst,
    mycpu_pipe_ctrl_if.slave bus
);

  logic                   id_valid_q, id_valid_d;
  stage_shadow_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic          mem_hold, mem_allow, ex_allow, id_go, id_allow, stall_id;
  logic          stall_rs, stall_rt;
  logic [1:0]    fwd_rs, fwd_rt;
  stage_shadow_t id_shadow;

  mycpu_hazard_cmp #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_cmp_rs (
    .addr   (bus.id_rs),
    .used   (bus.id_rs_used),
    .ex_s   (ex_q),
    .mem_s  (mem_q),
    .wb_s   (wb_q),
    .stall  (stall_rs),
    .fwd_sel(fwd_rs)
  );

  mycpu_hazard_cmp #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_cmp_rt (
    .addr   (bus.id_rt),
    .used   (bus.id_rt_used),
    .ex_s   (ex_q),
    .mem_s  (mem_q),
    .wb_s   (wb_q),
    .stall  (stall_rt),
    .fwd_sel(fwd_rt)
  );

  always_comb begin
    id_shadow         = '0;
    id_shadow.valid   = 1'b1;
    id_shadow.dest    = SHADOW_DEST_W'(bus.id_dest);
    id_shadow.wen     = bus.id_wen;
    id_shadow.is_load = bus.id_is_load;
    id_shadow.is_mem  = bus.id_is_mem;

    mem_hold  = mem_q.valid & mem_q.is_mem & ~bus.mem_done;
    mem_allow = ~mem_hold;
    ex_allow  = ~ex_q.valid | mem_allow;
    stall_id  = id_valid_q & (stall_rs | stall_rt);
    id_go     = id_valid_q & ~stall_id & ex_allow;
    id_allow  = ~id_valid_q | id_go;
  end

  always_comb begin
    id_valid_d  = id_valid_q;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = '0;
    stall_cnt_d = stall_cnt_q;

    if (id_allow) id_valid_d = bus.if_valid;
    // A stage that loads while its predecessor stays put receives a bubble.
    if (ex_allow) ex_d = id_go ? id_shadow : '0;
    if (mem_allow) begin
      mem_d = ex_q;
      wb_d  = mem_q;
    end
    if (id_valid_q && !id_go) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_q  <= 1'b0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    bus.pc_en       = id_allow;
    bus.if_id_en    = id_allow;
    bus.id_ex_en    = ex_allow;
    bus.ex_mem_en   = mem_allow;
    bus.mem_wb_en   = 1'b1;
    bus.id_valid    = id_valid_q;
    bus.ex_valid    = ex_q.valid;
    bus.mem_valid   = mem_q.valid;
    bus.wb_valid    = wb_q.valid;
    bus.stall_id    = stall_id;
    bus.br_redirect = id_go & bus.id_br_taken;
    bus.fwd_sel_a   = fwd_rs;
    bus.fwd_sel_b   = fwd_rt;
    bus.rf_wen      = wb_q.valid & wb_q.wen;
    bus.stall_cnt   = stall_cnt_q;
  end

endmodule

// File: tb/tb_mycpu_pipe_ctrl.sv
// Self-checking bench for mycpu_pipe_ctrl: directed hazard scenarios plus randomized traffic
// checked against a cycle-level pipeline model. Expectations follow FORWARD_EN when defined.
module tb_mycpu_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mycpu_pipe_ctrl_if #(.REG_ADDR_W(5), .STALL_CNT_W(32)) bus ();

  mycpu_pipe_ctrl #(.REG_ADDR_W(5), .STALL_CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_pass  = 0;

`ifdef FORWARD_EN
  localparam int         B2B_STALLS = 1;
  localparam logic [1:0] B2B_FWD    = 2'b01;
  localparam int         LW_STALLS  = 2;
  localparam logic [1:0] LW_FWD     = 2'b10;
`else
  localparam int         B2B_STALLS = 3;
  localparam logic [1:0] B2B_FWD    = 2'b00;
  localparam int         LW_STALLS  = 3;
  localparam logic [1:0] LW_FWD     = 2'b00;
`endif

  // Model: in-flight instructions in EX(1), MEM(2), WB(3), plus ID occupancy.
  typedef struct {
    bit       v;
    bit [4:0] d;
    bit       w;
    bit       l;
    bit       m;
  } ins_t;

  ins_t        st[1:3];
  bit          m_idv;
  int unsigned m_cnt;
  bit          e_hold, e_exa, e_stall, e_go, e_ida, e_br;
  bit [1:0]    e_fa, e_fb;

  task automatic model_reset();
    for (int s = 1; s <= 3; s++) st[s] = '{0, 0, 0, 0, 0};
    m_idv = 0;
    m_cnt = 0;
  endtask

  // {stall, sel}: nearest older writer of a non-zero source decides.
  function automatic bit [2:0] src_ref(bit [4:0] a, bit u);
    if (!u || a == 0) return 3'b000;
    for (int s = 1; s <= 3; s++) begin
      if (st[s].v && st[s].w && st[s].d == a) begin
`ifdef FORWARD_EN
        if (s == 1 || (s == 2 && st[s].l)) return 3'b100;
        return (s == 2) ? 3'b001 : 3'b010;
`else
        return 3'b100;
`endif
      end
    end
    return 3'b000;
  endfunction

  task automatic model_eval();
    bit [2:0] ra, rb;
    ra      = src_ref(bus.id_rs, bus.id_rs_used);
    rb      = src_ref(bus.id_rt, bus.id_rt_used);
    e_fa    = ra[1:0];
    e_fb    = rb[1:0];
    e_hold  = st[2].v && st[2].m && !bus.mem_done;
    e_exa   = !st[1].v || !e_hold;
    e_stall = m_idv && (ra[2] || rb[2]);
    e_go    = m_idv && !e_stall && e_exa;
    e_ida   = !m_idv || e_go;
    e_br    = e_go && bus.id_br_taken;
  endtask

  task automatic model_step();
    ins_t idi, bub;
    idi = '{1, bus.id_dest, bus.id_wen, bus.id_is_load, bus.id_is_mem};
    bub = '{0, 0, 0, 0, 0};
    if (m_idv && !e_go) m_cnt++;
    st[3] = e_hold ? bub : st[2];
    if (!e_hold) st[2] = st[1];
    if (e_exa) st[1] = e_go ? idi : bub;
    if (e_ida) m_idv = bus.if_valid;
  endtask

  // Advance one clock with the current inputs; returns at the following negedge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_id(bit [4:0] rs, bit [4:0] rt, bit rsu, bit rtu, bit [4:0] dest, bit wen,
                        bit ld, bit mem, bit br);
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rs_used  = rsu;
    bus.id_rt_used  = rtu;
    bus.id_dest     = dest;
    bus.id_wen      = wen;
    bus.id_is_load  = ld;
    bus.id_is_mem   = mem;
    bus.id_br_taken = br;
  endtask

  task automatic do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.if_valid = 0;
    bus.mem_done = 1;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++;
    if ({bus.id_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid} !== 4'b0000)
      $display("FAIL reset_valids got=%b want=0000",
               {bus.id_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid});
    else n_pass++;
    n_total++;
    if (bus.stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt got=%0d want=0", bus.stall_cnt);
    else n_pass++;
    n_total++;
    if ({bus.pc_en, bus.if_id_en, bus.stall_id, bus.br_redirect, bus.rf_wen} !== 5'b11000)
      $display("FAIL reset_ctrl got=%b want=11000",
               {bus.pc_en, bus.if_id_en, bus.stall_id, bus.br_redirect, bus.rf_wen});
    else n_pass++;
    n_total++;
    if ({bus.fwd_sel_a, bus.fwd_sel_b} !== 4'b0000)
      $display("FAIL reset_fwd got=%b want=0000", {bus.fwd_sel_a, bus.fwd_sel_b});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int         stalls = 0;
    bit         released = 0;
    logic [1:0] fsel = 2'b11;
    logic [31:0] c0;
    do_reset();
    bus.if_valid = 1;
    tick();
    set_id(1, 2, 1, 1, 3, 1, 0, 0, 0);   // addu $3,$1,$2
    tick();
    set_id(3, 1, 1, 1, 4, 1, 0, 0, 0);   // addu $4,$3,$1
    c0 = bus.stall_cnt;
    for (int i = 0; i < 6 && !released; i++) begin
      #1;
      if (i == 1) begin
        n_total++;
        if (bus.ex_valid !== 1'b0) $display("FAIL b2b_ex_bubble got=%b want=0", bus.ex_valid);
        else n_pass++;
      end
      if (bus.stall_id) stalls++;
      else begin
        released = 1;
        fsel = bus.fwd_sel_a;
      end
      tick();
    end
    n_total++;
    if (!released || stalls != B2B_STALLS)
      $display("FAIL b2b_stall_cycles got=%0d released=%0d want=%0d", stalls, released,
               B2B_STALLS);
    else n_pass++;
    n_total++;
    if (fsel !== B2B_FWD) $display("FAIL b2b_fwd_sel_a got=%b want=%b", fsel, B2B_FWD);
    else n_pass++;
    n_total++;
    if (bus.stall_cnt - c0 !== 32'(B2B_STALLS))
      $display("FAIL b2b_stall_cnt got=%0d want=%0d", bus.stall_cnt - c0, B2B_STALLS);
    else n_pass++;
  endtask

  task automatic test_load_branch();
    int         stalls = 0;
    int         br_early = 0;
    bit         released = 0;
    logic [1:0] fsel = 2'b11;
    logic       br_at_go = 0;
    do_reset();
    bus.if_valid = 1;
    tick();
    set_id(2, 0, 1, 0, 5, 1, 1, 1, 0);   // lw $5, completes in MEM same cycle
    tick();
    set_id(5, 0, 1, 1, 0, 0, 0, 0, 1);   // beq $5,$0 taken
    for (int i = 0; i < 6 && !released; i++) begin
      #1;
      if (bus.stall_id) begin
        stalls++;
        if (bus.br_redirect) br_early++;
      end else begin
        released = 1;
        fsel = bus.fwd_sel_a;
        br_at_go = bus.br_redirect;
      end
      tick();
    end
    n_total++;
    if (!released || stalls != LW_STALLS)
      $display("FAIL lw_br_stall_cycles got=%0d released=%0d want=%0d", stalls, released,
               LW_STALLS);
    else n_pass++;
    n_total++;
    if (fsel !== LW_FWD) $display("FAIL lw_br_fwd_sel_a got=%b want=%b", fsel, LW_FWD);
    else n_pass++;
    n_total++;
    if (br_early != 0 || br_at_go !== 1'b1)
      $display("FAIL lw_br_redirect during_stall=%0d at_go=%b want 0 and 1", br_early, br_at_go);
    else n_pass++;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);   // delay slot, not a branch
    #1;
    n_total++;
    if (bus.br_redirect !== 1'b0) $display("FAIL lw_br_one_shot got=%b want=0", bus.br_redirect);
    else n_pass++;
    tick();
  endtask

  task automatic test_r0();
    int bad = 0;
    do_reset();
    bus.if_valid = 1;
    tick();
    set_id(1, 2, 1, 1, 0, 1, 0, 0, 0);   // addu $0,$1,$2
    tick();
    set_id(0, 0, 1, 1, 6, 1, 0, 0, 0);   // addu $6,$0,$0
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.stall_id !== 1'b0 || bus.fwd_sel_a !== 2'b00 || bus.fwd_sel_b !== 2'b00) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL r0_no_hazard got=%0d bad cycles want=0", bad);
    else n_pass++;
  endtask

  task automatic test_mem_hold();
    logic [31:0] c0;
    int          en_bad = 0;
    int          wb_bad = 0;
    do_reset();
    bus.if_valid = 1;
    tick();
    set_id(1, 2, 1, 1, 0, 0, 0, 1, 0);   // sw
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.mem_done = 0;                    // sw now in MEM
    c0 = bus.stall_cnt;
    for (int i = 0; i < 4; i++) begin
      #1;
      if ({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en} !== 4'b0000) en_bad++;
      tick();
      if (bus.wb_valid !== 1'b0) wb_bad++;
    end
    n_total++;
    if (en_bad != 0) $display("FAIL mem_hold_enables got=%0d bad cycles want=0", en_bad);
    else n_pass++;
    n_total++;
    if (wb_bad != 0) $display("FAIL mem_hold_wb_bubble got=%0d bad cycles want=0", wb_bad);
    else n_pass++;
    bus.mem_done = 1;
    #1;
    n_total++;
    if (bus.stall_cnt - c0 !== 32'd4)
      $display("FAIL mem_hold_stall_cnt got=%0d want=4", bus.stall_cnt - c0);
    else n_pass++;
    n_total++;
    if (bus.ex_mem_en !== 1'b1) $display("FAIL mem_release got=%b want=1", bus.ex_mem_en);
    else n_pass++;
    tick();
    n_total++;
    if (bus.wb_valid !== 1'b1) $display("FAIL mem_sw_retire got=%b want=1", bus.wb_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.if_valid = 1;
    tick();
    set_id(1, 2, 1, 1, 3, 1, 0, 0, 0);
    tick();
    set_id(3, 1, 1, 1, 4, 1, 0, 0, 0);
    #1;
    n_total++;
    if (bus.stall_id !== 1'b1) $display("FAIL mid_stall_setup got=%b want=1", bus.stall_id);
    else n_pass++;
    #1;
    rst = 0;                             // asynchronous, between clock edges
    #1;
    n_total++;
    if ({bus.id_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.stall_id} !== 5'b0 ||
        bus.stall_cnt !== 32'd0 || bus.pc_en !== 1'b1)
      $display("FAIL async_reset valids_stall=%b cnt=%0d pc_en=%b want 00000 0 1",
               {bus.id_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.stall_id},
               bus.stall_cnt, bus.pc_en);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_random();
    logic [47:0] got, exp;
    int unsigned kind;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      kind = $urandom_range(0, 3);
      set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), kind != 2,
             kind == 1, kind == 1 || kind == 2, $urandom_range(0, 3) == 0);
      bus.if_valid = $urandom_range(0, 4) != 0;
      bus.mem_done = $urandom_range(0, 2) != 0;
      #1;
      model_eval();
      got = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en, bus.id_valid,
             bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.stall_id, bus.br_redirect,
             bus.fwd_sel_a, bus.fwd_sel_b, bus.rf_wen, bus.stall_cnt};
      exp = {e_ida, e_ida, e_exa, !e_hold, 1'b1, m_idv, st[1].v, st[2].v, st[3].v, e_stall,
             e_br, e_fa, e_fb, st[3].v && st[3].w, m_cnt};
      n_total++;
      if (got !== exp) $display("FAIL random_cycle_%0d got=%h want=%h", c, got, exp);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_branch();
    test_r0();
    test_mem_hold();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
